// File: rtl/io_bus_pkg.sv
// -----------------------------------------------------------------------------
// io_bus_pkg
// Shared definitions for IO_bus slave endpoints: bus widths, RW encoding and
// the slave handshake state type.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package io_bus_pkg;

    localparam int unsigned BUS_DATA_WIDTH = 32;
    localparam int unsigned BUS_ADDR_WIDTH = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } slave_state_t;

endpackage

// File: rtl/bit_synchroniser.sv
// -----------------------------------------------------------------------------
// bit_synchroniser
// Multi-flop synchroniser for a single asynchronous level signal.
// Ports:
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset (chain clears to 0)
//   i_d      asynchronous input level
//   o_q      synchronised level, STAGES clocks of latency
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module bit_synchroniser #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/io_bus_slave_regbank.sv
// -----------------------------------------------------------------------------
// io_bus_slave_regbank
// IO_bus four-phase handshake slave with an address window of NUM_REGS
// registers. Slots flagged in RO_MASK read the matching status_in word and
// ignore writes. Every output is registered and is zero while the slave is not
// answering, so several slaves on one master can be OR-combined.
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_handshake_1  master request, asynchronous to i_clk
//   i_rw           1 = read, 0 = write
//   i_reg_address  register address
//   i_data_out     write data from the master
//   o_data_in      read data to the master, 0 unless acknowledging a read
//   o_handshake_2  slave acknowledge
//   o_reg_q        R/W register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_status_in    read-only sources, only RO_MASK slots are used
//   o_wr_strobe    one-cycle pulse when register i is written
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module io_bus_slave_regbank
    import io_bus_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH  = BUS_DATA_WIDTH,
    parameter int unsigned            ADDR_WIDTH  = BUS_ADDR_WIDTH,
    parameter int unsigned            NUM_REGS    = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
    parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0]  RESET_VAL   = '0,
    parameter int unsigned            SYNC_STAGES = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_handshake_1,
    input  logic                           i_rw,
    input  logic [ADDR_WIDTH-1:0]          i_reg_address,
    input  logic [DATA_WIDTH-1:0]          i_data_out,
    output logic [DATA_WIDTH-1:0]          o_data_in,
    output logic                           o_handshake_2,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] i_status_in,
    output logic [NUM_REGS-1:0]            o_wr_strobe
);

    localparam int unsigned           IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0]   NUM_REGS_EXT = (ADDR_WIDTH + 1)'(NUM_REGS);

    logic                   w_h1_s;
    logic [ADDR_WIDTH:0]    w_offset;
    logic                   w_hit;
    logic [IDX_W-1:0]       w_idx;
    logic [DATA_WIDTH-1:0]  w_status [NUM_REGS];

    slave_state_t           r_state;
    slave_state_t           w_state_next;
    logic                   r_hs2;
    logic                   w_hs2_next;
    logic [DATA_WIDTH-1:0]  r_data_in;
    logic [DATA_WIDTH-1:0]  w_data_next;
    logic [NUM_REGS-1:0]    r_wr_strobe;
    logic [NUM_REGS-1:0]    w_strobe_next;
    logic                   r_rw;
    logic [IDX_W-1:0]       r_idx;
    logic                   w_latch;
    logic                   w_wr_en;
    logic [DATA_WIDTH-1:0]  r_regs [NUM_REGS];

    bit_synchroniser #(
        .STAGES (SYNC_STAGES)
    ) u_h1_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_handshake_1),
        .o_q     (w_h1_s)
    );

    // One extra bit keeps addresses below BASE_ADDR from wrapping into the window
    // and lets a window ending at the top of the address space decode correctly.
    assign w_offset = {1'b0, i_reg_address} - {1'b0, BASE_ADDR};
    assign w_hit    = w_h1_s && (w_offset < NUM_REGS_EXT);
    assign w_idx    = w_offset[IDX_W-1:0];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slots
        assign o_reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
        assign w_status[g] = i_status_in[g*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        w_state_next  = r_state;
        w_hs2_next    = r_hs2;
        w_data_next   = r_data_in;
        w_strobe_next = '0;
        w_latch       = 1'b0;
        w_wr_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_state_next = S_ACCESS;
                    w_latch      = 1'b1;
                    // Register and strobe update on the edge into S_ACCESS, so the strobe
                    // is high during the S_ACCESS cycle with o_reg_q already updated.
                    if (i_rw == RW_WRITE && !RO_MASK[w_idx]) begin
                        w_wr_en              = 1'b1;
                        w_strobe_next[w_idx] = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                // Completes even if the request was already withdrawn.
                w_state_next = S_ACK;
                w_hs2_next   = 1'b1;
                if (r_rw == RW_READ) begin
                    w_data_next = RO_MASK[r_idx] ? w_status[r_idx] : r_regs[r_idx];
                end
            end
            S_ACK: begin
                if (!w_h1_s) begin
                    w_state_next = S_IDLE;
                    w_hs2_next   = 1'b0;
                    w_data_next  = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_hs2_next   = 1'b0;
                w_data_next  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_hs2       <= 1'b0;
            r_data_in   <= '0;
            r_wr_strobe <= '0;
            r_rw        <= RW_WRITE;
            r_idx       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_hs2       <= w_hs2_next;
            r_data_in   <= w_data_next;
            r_wr_strobe <= w_strobe_next;
            if (w_latch) begin
                r_rw  <= i_rw;
                r_idx <= w_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (w_wr_en) begin
            r_regs[w_idx] <= i_data_out;
        end
    end

    assign o_handshake_2 = r_hs2;
    assign o_data_in     = r_data_in;
    assign o_wr_strobe   = r_wr_strobe;

endmodule

// File: tb/tb_io_bus_slave_regbank.sv
// Two slaves share one bus (windows 0x10..0x17 and 0xF8..0xFF); their outputs are OR-combined.
`timescale 1ns/1ps
module tb_io_bus_slave_regbank;
    import io_bus_pkg::*;

    localparam int unsigned    DW    = 32;
    localparam int unsigned    NR    = 8;
    localparam logic [7:0]     BASE0 = 8'h10;
    localparam logic [7:0]     BASE1 = 8'hF8;
    localparam logic [7:0]     RO0   = 8'h80;
    localparam logic [7:0]     RO1   = 8'h01;
    localparam logic [31:0]    RV0   = 32'h5A5A_0001;
    localparam logic [31:0]    RV1   = 32'h0000_0000;
    localparam int             SYNC0 = 2;
    localparam int             SYNC1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic h1 = 1'b0;
    logic rw = 1'b0;
    logic [7:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [NR*DW-1:0] stat0 = '0;
    logic [NR*DW-1:0] stat1 = '0;
    logic [NR*DW-1:0] regq0, regq1;
    logic [31:0] din0, din1;
    logic hs0, hs1;
    logic [NR-1:0] stb0, stb1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    io_bus_slave_regbank #(
        .NUM_REGS (NR), .BASE_ADDR (BASE0), .RO_MASK (RO0), .RESET_VAL (RV0),
        .SYNC_STAGES (SYNC0)
    ) u_dut0 (
        .i_clk (clk), .i_rst_n (rst_n), .i_handshake_1 (h1), .i_rw (rw),
        .i_reg_address (addr), .i_data_out (wdata), .o_data_in (din0),
        .o_handshake_2 (hs0), .o_reg_q (regq0), .i_status_in (stat0), .o_wr_strobe (stb0)
    );

    io_bus_slave_regbank #(
        .NUM_REGS (NR), .BASE_ADDR (BASE1), .RO_MASK (RO1), .RESET_VAL (RV1),
        .SYNC_STAGES (SYNC1)
    ) u_dut1 (
        .i_clk (clk), .i_rst_n (rst_n), .i_handshake_1 (h1), .i_rw (rw),
        .i_reg_address (addr), .i_data_out (wdata), .o_data_in (din1),
        .o_handshake_2 (hs1), .o_reg_q (regq1), .i_status_in (stat1), .o_wr_strobe (stb1)
    );

    // Reference model: plain register arrays and address arithmetic.
    logic [31:0] m_reg [2][NR];

    typedef struct {
        logic [31:0]    data;
        logic [15:0]    strobe;
        logic [255:0]   regs0;
        logic [255:0]   regs1;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_reg[0][i] = RV0;
            m_reg[1][i] = RV1;
        end
    endtask

    function automatic logic [255:0] pack(input int dn);
        logic [255:0] p;
        for (int i = 0; i < NR; i++) p[i*32 +: 32] = m_reg[dn][i];
        return p;
    endfunction

    function automatic logic [31:0] stat_word(input int dn, input int idx);
        return (dn == 0) ? stat0[idx*32 +: 32] : stat1[idx*32 +: 32];
    endfunction

    task automatic decode(input logic [7:0] a, output int dn, output int idx);
        int ai;
        ai = int'(a);
        dn = -1;
        idx = 0;
        if (ai >= int'(BASE0) && ai < int'(BASE0) + NR) begin
            dn = 0;
            idx = ai - int'(BASE0);
        end else if (ai >= int'(BASE1) && ai < int'(BASE1) + NR) begin
            dn = 1;
            idx = ai - int'(BASE1);
        end
    endtask

    // Applies the transaction to the model and queues the response the monitor must see.
    task automatic predict(input logic r, input logic [7:0] a, input logic [31:0] d,
                           output int dn);
        int idx;
        exp_t e;
        logic [7:0] ro_m;
        decode(a, dn, idx);
        if (dn >= 0) begin
            ro_m = (dn == 0) ? RO0 : RO1;
            e.data = '0;
            e.strobe = '0;
            if (r) e.data = ro_m[idx] ? stat_word(dn, idx) : m_reg[dn][idx];
            else if (!ro_m[idx]) begin
                m_reg[dn][idx] = d;
                e.strobe[dn*8 + idx] = 1'b1;
            end
            e.regs0 = pack(0);
            e.regs1 = pack(1);
            sb.push_back(e);
        end
    endtask

    task automatic xfer(input logic r, input logic [7:0] a, input logic [31:0] d);
        int dn, k, sync;
        logic bad;
        predict(r, a, d, dn);
        rw = r;
        addr = a;
        wdata = d;
        h1 = 1'b1;
        if (dn < 0) begin
            bad = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (hs0 || hs1 || (din0 | din1) != 0) bad = 1'b1;
            end
            chk("miss_quiet", bad, 0);
            h1 = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            sync = (dn == 0) ? SYNC0 : SYNC1;
            k = 0;
            while (!(hs0 || hs1) && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("ack_latency", k, sync + 2);
            h1 = 1'b0;
            k = 0;
            while ((hs0 || hs1) && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("release_latency", k, sync + 1);
            chk("rdata_cleared", din0 | din1, 0);
            repeat (2) @(negedge clk);
        end
    endtask

    // Scoreboard monitor: one pop per rising acknowledge.
    initial begin
        logic hs_prev;
        int st_cnt;
        logic [15:0] st_acc;
        exp_t e;
        hs_prev = 1'b0;
        st_cnt = 0;
        st_acc = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hs_prev = 1'b0;
                st_cnt = 0;
                st_acc = '0;
            end else begin
                if ({stb1, stb0} != 0) begin
                    st_cnt++;
                    st_acc |= {stb1, stb0};
                end
                if ((hs0 || hs1) && !hs_prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("read_data", din0 | din1, e.data);
                        chk("wr_strobe", st_acc, e.strobe);
                        chk("wr_strobe_cycles", st_cnt, (e.strobe != 0) ? 1 : 0);
                        chk("reg_q_slave0", regq0, e.regs0);
                        chk("reg_q_slave1", regq1, e.regs1);
                    end
                    st_cnt = 0;
                    st_acc = '0;
                end
                hs_prev = hs0 || hs1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dn, k, r;
        logic [7:0] a;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_hs2", hs0 | hs1, 0);
        chk("reset_data_in", din0 | din1, 0);
        chk("reset_strobe", {stb1, stb0}, 0);
        chk("reset_reg_q0", regq0, {NR{RV0}});
        chk("reset_reg_q1", regq1, {NR{RV1}});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic write/read, read-only slot, window edges and misses.
        xfer(RW_WRITE, 8'h13, 32'hDEADBEEF);
        xfer(RW_READ,  8'h13, 32'h0);
        stat0[7*32 +: 32] = 32'h0000_1234;
        stat1[0*32 +: 32] = 32'hFEED_0F00;
        xfer(RW_READ,  8'h17, 32'h0);
        xfer(RW_WRITE, 8'h17, 32'hCAFE_F00D);
        xfer(RW_READ,  8'h17, 32'h0);
        xfer(RW_WRITE, 8'h18, 32'h1111_1111);
        xfer(RW_READ,  8'h0F, 32'h0);
        xfer(RW_READ,  8'hF7, 32'h0);
        xfer(RW_WRITE, 8'hFF, 32'h7777_AAAA);
        xfer(RW_READ,  8'hFF, 32'h0);
        xfer(RW_READ,  8'hF8, 32'h0);
        xfer(RW_WRITE, 8'h10, 32'h0BAD_CAFE);

        // Request withdrawn after one clock: access still completes, one-cycle ack.
        predict(RW_WRITE, 8'h12, 32'h1234_5678, dn);
        rw = RW_WRITE;
        addr = 8'h12;
        wdata = 32'h1234_5678;
        h1 = 1'b1;
        @(negedge clk);
        h1 = 1'b0;
        k = 0;
        repeat (10) begin
            @(negedge clk);
            if (hs0 || hs1) k++;
        end
        chk("short_req_ack_cycles", k, 1);
        xfer(RW_READ, 8'h12, 32'h0);

        // Reset while acknowledging: outputs return to reset values without a clock edge.
        predict(RW_WRITE, 8'h15, 32'h5555_6666, dn);
        rw = RW_WRITE;
        addr = 8'h15;
        wdata = 32'h5555_6666;
        h1 = 1'b1;
        k = 0;
        while (!(hs0 || hs1) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("pre_reset_ack", hs0 | hs1, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_hs2", hs0 | hs1, 0);
        chk("async_reset_reg_q0", regq0, {NR{RV0}});
        chk("async_reset_reg_q1", regq1, {NR{RV1}});
        model_reset();
        h1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        xfer(RW_READ, 8'h15, 32'h0);

        // Randomised traffic.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NR; i++) begin
                stat0[i*32 +: 32] = $urandom;
                stat1[i*32 +: 32] = $urandom;
            end
            r = $urandom_range(0, 9);
            if (r < 4)      a = BASE0 + 8'($urandom_range(0, NR - 1));
            else if (r < 8) a = BASE1 + 8'($urandom_range(0, NR - 1));
            else            a = 8'($urandom_range(0, 255));
            xfer(1'($urandom_range(0, 1)), a, $urandom);
        end

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
